// File: rtl/morse_keyer.sv
// Morse keyer: accepts ASCII characters over a valid/ready handshake and
// keys them out as ITU Morse on KEY_OUT (1 = mark, LED on).
//
// Handshake: a character transfers on any rising CLK edge where
// CHAR_VALID & CHAR_READY are both 1. CHAR_READY is high only in IDLE, so
// once a character is taken the producer may drop or change CHAR_DATA
// freely. A character offered while busy simply waits.
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES = 2097152
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CHAR_VALID,
  input  logic [7:0] CHAR_DATA,
  output logic       CHAR_READY,
  output logic       KEY_OUT,
  output logic       BUSY,
  output logic       CHAR_ERR
);

  localparam int unsigned   CW     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP_EL, GAP_CH} state_t;

  state_t        state_q;
  logic [CW-1:0] tick_q;   // clocks left in the current unit
  logic [CW-1:0] tick_d;
  logic [2:0]    units_q;  // whole units left after the current one
  logic [4:0]    elems_q;  // remaining elements, next one at bit 4
  logic [2:0]    left_q;   // elements still to send after the current mark
  logic          ready_q;
  logic          key_q;
  logic          busy_q;
  logic          err_q;

  logic [7:0]    fold_c;
  logic [7:0]    rom_code;
  logic [2:0]    code_len;
  logic [4:0]    code_el;
  logic          accept;
  logic          is_space;

  // Code table: {len, elems} with elements left-aligned, first element in
  // bit 4, dot = 0, dash = 1. len = 0 marks characters with no Morse code.
  function automatic logic [7:0] code_of(input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    case (c)
      8'h41: r = {3'd2, 5'b01000}; // A .-
      8'h42: r = {3'd4, 5'b10000}; // B -...
      8'h43: r = {3'd4, 5'b10100}; // C -.-.
      8'h44: r = {3'd3, 5'b10000}; // D -..
      8'h45: r = {3'd1, 5'b00000}; // E .
      8'h46: r = {3'd4, 5'b00100}; // F ..-.
      8'h47: r = {3'd3, 5'b11000}; // G --.
      8'h48: r = {3'd4, 5'b00000}; // H ....
      8'h49: r = {3'd2, 5'b00000}; // I ..
      8'h4A: r = {3'd4, 5'b01110}; // J .---
      8'h4B: r = {3'd3, 5'b10100}; // K -.-
      8'h4C: r = {3'd4, 5'b01000}; // L .-..
      8'h4D: r = {3'd2, 5'b11000}; // M --
      8'h4E: r = {3'd2, 5'b10000}; // N -.
      8'h4F: r = {3'd3, 5'b11100}; // O ---
      8'h50: r = {3'd4, 5'b01100}; // P .--.
      8'h51: r = {3'd4, 5'b11010}; // Q --.-
      8'h52: r = {3'd3, 5'b01000}; // R .-.
      8'h53: r = {3'd3, 5'b00000}; // S ...
      8'h54: r = {3'd1, 5'b10000}; // T -
      8'h55: r = {3'd3, 5'b00100}; // U ..-
      8'h56: r = {3'd4, 5'b00010}; // V ...-
      8'h57: r = {3'd3, 5'b01100}; // W .--
      8'h58: r = {3'd4, 5'b10010}; // X -..-
      8'h59: r = {3'd4, 5'b10110}; // Y -.--
      8'h5A: r = {3'd4, 5'b11000}; // Z --..
      8'h30: r = {3'd5, 5'b11111}; // 0 -----
      8'h31: r = {3'd5, 5'b01111}; // 1 .----
      8'h32: r = {3'd5, 5'b00111}; // 2 ..---
      8'h33: r = {3'd5, 5'b00011}; // 3 ...--
      8'h34: r = {3'd5, 5'b00001}; // 4 ....-
      8'h35: r = {3'd5, 5'b00000}; // 5 .....
      8'h36: r = {3'd5, 5'b10000}; // 6 -....
      8'h37: r = {3'd5, 5'b11000}; // 7 --...
      8'h38: r = {3'd5, 5'b11100}; // 8 ---..
      8'h39: r = {3'd5, 5'b11110}; // 9 ----.
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Case folding, code lookup and the free-running unit timer's next value.
  always_comb begin
    fold_c = CHAR_DATA;
    if (CHAR_DATA >= 8'h61 && CHAR_DATA <= 8'h7A) fold_c = CHAR_DATA - 8'h20;
    rom_code = code_of(fold_c);
    code_len = rom_code[7:5];
    code_el  = rom_code[4:0];
    is_space = (fold_c == 8'h20);
    accept   = CHAR_VALID & ready_q;
    tick_d   = (tick_q == '0) ? RELOAD : tick_q - 1'b1;
  end

  // Keyer FSM with all outputs registered; a unit ends when tick_q hits 0,
  // and the state ends when that happens with no whole units left.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tick_q  <= '0;
      units_q <= 3'd0;
      elems_q <= 5'd0;
      left_q  <= 3'd0;
      ready_q <= 1'b0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          key_q   <= 1'b0;
          if (accept) begin
            tick_q <= RELOAD;
            if (is_space) begin
              // Four silent units on top of the previous 3-unit gap.
              state_q <= GAP_CH;
              units_q <= 3'd3;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end else if (code_len != 3'd0) begin
              state_q <= MARK;
              key_q   <= 1'b1;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
              units_q <= code_el[4] ? 3'd2 : 3'd0;
              elems_q <= {code_el[3:0], 1'b0};
              left_q  <= code_len - 3'd1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        MARK: begin
          tick_q <= tick_d;
          if (tick_q == '0) begin
            if (units_q == 3'd0) begin
              key_q <= 1'b0;
              if (left_q == 3'd0) begin
                state_q <= GAP_CH;
                units_q <= 3'd2;
              end else begin
                state_q <= GAP_EL;
                units_q <= 3'd0;
              end
            end else begin
              units_q <= units_q - 3'd1;
            end
          end
        end
        GAP_EL: begin
          tick_q <= tick_d;
          if (tick_q == '0) begin
            if (units_q == 3'd0) begin
              state_q <= MARK;
              key_q   <= 1'b1;
              units_q <= elems_q[4] ? 3'd2 : 3'd0;
              elems_q <= {elems_q[3:0], 1'b0};
              left_q  <= left_q - 3'd1;
            end else begin
              units_q <= units_q - 3'd1;
            end
          end
        end
        GAP_CH: begin
          tick_q <= tick_d;
          if (tick_q == '0) begin
            if (units_q == 3'd0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              units_q <= units_q - 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CHAR_READY = ready_q;
  assign KEY_OUT    = key_q;
  assign BUSY       = busy_q;
  assign CHAR_ERR   = err_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with a short unit. Expected {BUSY, KEY_OUT}
// per clock is expanded from a unit-level pattern and queued when a
// character is driven, then popped one per clock after the transfer edge.
module tb_morse_keyer;

  localparam int unsigned UNIT = 4;
  localparam int W = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CHAR_VALID = 1'b0;
  logic [7:0] CHAR_DATA = 8'h00;
  logic       CHAR_READY;
  logic       KEY_OUT;
  logic       BUSY;
  logic       CHAR_ERR;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  morse_keyer #(.UNIT_CYCLES(UNIT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CHAR_VALID (CHAR_VALID),
    .CHAR_DATA  (CHAR_DATA),
    .CHAR_READY (CHAR_READY),
    .KEY_OUT    (KEY_OUT),
    .BUSY       (BUSY),
    .CHAR_ERR   (CHAR_ERR)
  );

  // Clock and global watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (CHAR_READY !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_ready_wait"}, CHAR_READY, 1);
  endtask

  // Drive one character and check it clock by clock against pat, a string
  // of unit values ('1' = mark); afterwards expect the single IDLE cycle.
  task automatic send(input logic [7:0] c, input string pat, input bit keep);
    logic [W-1:0] e;
    bit first;
    string tag;
    tag = $sformatf("ch%02h", c);
    for (int i = 0; i < pat.len(); i++)
      for (int k = 0; k < int'(UNIT); k++)
        exp_q.push_back({1'b1, pat[i] == 8'h31});
    wait_ready(tag);
    CHAR_DATA  = c;
    CHAR_VALID = 1'b1;
    tick();
    if (!keep) CHAR_VALID = 1'b0;
    first = 1'b1;
    while (exp_q.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = exp_q.pop_front();
      chk({tag, "_key"},  KEY_OUT,    e[0]);
      chk({tag, "_busy"}, BUSY,       e[1]);
      chk({tag, "_err"},  CHAR_ERR,   0);
      chk({tag, "_rdy"},  CHAR_READY, 0);
    end
    tick();
    chk({tag, "_idle_busy"},  BUSY,       0);
    chk({tag, "_idle_ready"}, CHAR_READY, 1);
    chk({tag, "_idle_key"},   KEY_OUT,    0);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    chk("rst_key",   KEY_OUT,    0);
    chk("rst_busy",  BUSY,       0);
    chk("rst_ready", CHAR_READY, 0);
    chk("rst_err",   CHAR_ERR,   0);
    RST = 1'b0;
    tick();
    chk("post_rst_ready", CHAR_READY, 1);
    chk("post_rst_busy",  BUSY,       0);

    // 1. Single dot.
    send(8'h45, "1000", 1'b0);

    // 2. SOS with CHAR_VALID held across characters.
    send(8'h53, "10101000", 1'b1);
    send(8'h4F, "11101110111000", 1'b1);
    send(8'h53, "10101000", 1'b0);

    // 3. Lowercase folds to uppercase.
    send(8'h61, "10111000", 1'b0);

    // 4. Word gap: T then space.
    send(8'h54, "111000", 1'b0);
    send(8'h20, "0000", 1'b0);

    // 5. Unsupported character pulses CHAR_ERR and stays in IDLE.
    wait_ready("hash");
    CHAR_DATA  = 8'h23;
    CHAR_VALID = 1'b1;
    tick();
    CHAR_VALID = 1'b0;
    chk("hash_err",   CHAR_ERR,   1);
    chk("hash_key",   KEY_OUT,    0);
    chk("hash_ready", CHAR_READY, 1);
    chk("hash_busy",  BUSY,       0);
    send(8'h45, "1000", 1'b0);

    // 6. Reset in the middle of the first dash of 'O'.
    wait_ready("rst_o");
    CHAR_DATA  = 8'h4F;
    CHAR_VALID = 1'b1;
    tick();
    CHAR_VALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("mid_o_key",  KEY_OUT, 1);
      chk("mid_o_busy", BUSY,    1);
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_key",   KEY_OUT,    0);
    chk("mid_rst_busy",  BUSY,       0);
    chk("mid_rst_ready", CHAR_READY, 0);
    tick();
    chk("after_rst_ready", CHAR_READY, 1);
    chk("after_rst_key",   KEY_OUT,    0);
    send(8'h45, "1000", 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
